cordic_angle_sequencer: RTL and testbench

//  Sequences the CORDIC micro-rotations: steps an iteration counter and drives the

---
 rtl/cordic_angle_sequencer.sv | 117 +++++++++++
 tb/tb_cordic_angle_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_angle_sequencer
//  Description : Walks the CORDIC iteration index and fetches one arctangent
//                word per micro-rotation from a 1-cycle registered ROM. Each
//                word is presented downstream under a valid/ack handshake.
//                A one-cycle done pulse follows the final acknowledge.
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_angle_sequencer #(
    parameter int W    = 32,
    parameter int ITER = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beg_seq,
    input  logic         ack_iter,
    input  logic [W-1:0] rom_data,
    output logic         rom_enable,
    output logic [4:0]   rom_address,
    output logic [W-1:0] angle_out,
    output logic [4:0]   iter_count,
    output logic         iter_valid,
    output logic         busy,
    output logic         done
);

    // Index of the final iteration; ITER is limited to 1..32 so this fits 5 bits.
    localparam logic [4:0] c_LAST_IDX = 5'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_rom_enable;
    logic [4:0]   r_rom_address;
    logic [W-1:0] r_angle;
    logic [4:0]   r_iter_count;
    logic         r_iter_valid;
    logic         r_busy;
    logic         r_done;

    logic [4:0]   w_next_idx;

    assign w_next_idx = r_iter_count + 5'd1;

    // Sequencer: FETCH drives the ROM, CAPTURE latches its registered output,
    // PRESENT holds the word until the downstream adder acknowledges it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rom_enable  <= 1'b0;
            r_rom_address <= 5'd0;
            r_angle       <= '0;
            r_iter_count  <= 5'd0;
            r_iter_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped so a
                    // back-to-back request cannot be mistaken for a restart.
                    if (beg_seq && !r_done) begin
                        r_state       <= S_FETCH;
                        r_busy        <= 1'b1;
                        r_rom_enable  <= 1'b1;
                        r_rom_address <= 5'd0;
                        r_iter_count  <= 5'd0;
                    end
                end
                S_FETCH: begin
                    r_rom_enable <= 1'b0;
                    r_state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_angle      <= rom_data;
                    r_iter_valid <= 1'b1;
                    r_state      <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (ack_iter) begin
                        r_iter_valid <= 1'b0;
                        if (r_iter_count == c_LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_iter_count  <= w_next_idx;
                            r_rom_address <= w_next_idx;
                            r_rom_enable  <= 1'b1;
                            r_state       <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_enable  = r_rom_enable;
    assign rom_address = r_rom_address;
    assign angle_out   = r_angle;
    assign iter_count  = r_iter_count;
    assign iter_valid  = r_iter_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cordic_angle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_angle_sequencer
//  Description : Scoreboard bench for cordic_angle_sequencer. Three instances
//                (ITER = 24, 32, 1) share clock and reset; only one runs a
//                sequence at a time, so a single ordered queue holds the
//                expected handshakes and done events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_angle_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        beg_seq     [NI];
    logic        ack_iter    [NI];
    logic        rom_enable  [NI];
    logic [4:0]  rom_address [NI];
    logic [31:0] angle_out   [NI];
    logic [4:0]  iter_count  [NI];
    logic        iter_valid  [NI];
    logic        busy        [NI];
    logic        done        [NI];

    typedef struct {
        int          inst;
        int          k;
        logic [31:0] angle;
        bit          is_done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_start = 0;

    // Ack backpressure control: stall instance stall_inst at index stall_k.
    int   stall_inst = 0;
    int   stall_k = 0;
    int   stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // atan(2^-i) as IEEE-754 single; from i=12 on it rounds to exactly 2^-i.
    function automatic logic [31:0] atan_word(int i);
        logic [7:0] e;
        e = 8'(127 - i);
        case (i)
            0:  return 32'h3f490fdb;
            1:  return 32'h3eed6338;
            2:  return 32'h3e7adbb0;
            3:  return 32'h3dfeadd5;
            4:  return 32'h3d7faade;
            5:  return 32'h3cffeaae;
            6:  return 32'h3c7ffaab;
            7:  return 32'h3bfffeab;
            8:  return 32'h3b7fffab;
            9:  return 32'h3affffeb;
            10: return 32'h3a7ffffb;
            11: return 32'h39ffffff;
            default: return {1'b0, e, 23'd0};
        endcase
    endfunction

    task automatic chk_eq(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int IT = (gi == 0) ? 24 : ((gi == 1) ? 32 : 1);

            logic [31:0] rom_q;
            int          en_cnt = 0;
            logic        prev_en = 1'b0;
            logic        prev_done = 1'b0;
            exp_t        e;

            cordic_angle_sequencer #(.W(32), .ITER(IT)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .beg_seq     (beg_seq[gi]),
                .ack_iter    (ack_iter[gi]),
                .rom_data    (rom_q),
                .rom_enable  (rom_enable[gi]),
                .rom_address (rom_address[gi]),
                .angle_out   (angle_out[gi]),
                .iter_count  (iter_count[gi]),
                .iter_valid  (iter_valid[gi]),
                .busy        (busy[gi]),
                .done        (done[gi])
            );

            // ROM model: registered read, zero output while disabled.
            always @(posedge clk)
                rom_q <= rom_enable[gi] ? atan_word(int'(rom_address[gi])) : 32'd0;

            // Monitor: compares presented words and done pulses with the queue.
            always @(negedge clk) begin
                prev_en   <= rom_enable[gi];
                prev_done <= done[gi];
                if (rom_enable[gi] === 1'b1) begin
                    en_cnt <= en_cnt + 1;
                    chk_eq("rom_enable_single_cycle", 32'(prev_en), 32'd0);
                end
                if (rom_enable[gi] === 1'b1 || iter_valid[gi] === 1'b1)
                    chk_eq("rom_address_vs_iter_count", 32'(rom_address[gi]), 32'(iter_count[gi]));
                if (iter_valid[gi] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk_eq("unexpected_iter_valid", 32'd1, 32'd0);
                    end else begin
                        e = sb_q[0];
                        chk_eq("valid_instance", 32'(gi), 32'(e.inst));
                        chk_eq("valid_not_done_slot", 32'd0, 32'(e.is_done));
                        chk_eq("iter_count", 32'(iter_count[gi]), 32'(e.k));
                        chk_eq("angle_out", angle_out[gi], e.angle);
                        chk_eq("busy_while_valid", 32'(busy[gi]), 32'd1);
                        if (ack_iter[gi] === 1'b1)
                            void'(sb_q.pop_front());
                    end
                end
                if (done[gi] === 1'b1) begin
                    chk_eq("done_pulse_width", 32'(prev_done), 32'd0);
                    chk_eq("busy_in_done_cycle", 32'(busy[gi]), 32'd0);
                    if (sb_q.size() == 0) begin
                        chk_eq("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q[0];
                        chk_eq("done_instance", 32'(gi), 32'(e.inst));
                        chk_eq("done_expected", 32'd1, 32'(e.is_done));
                        if (e.is_done && e.inst == gi)
                            void'(sb_q.pop_front());
                    end
                end
            end
        end
    endgenerate

    // Ack driver: acknowledge immediately unless a stall is programmed.
    initial begin
        for (int i = 0; i < NI; i++) ack_iter[i] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (stall_left > 0 && i == stall_inst && iter_valid[i] === 1'b1 &&
                    iter_count[i] == 5'(stall_k)) begin
                    ack_iter[i] = 1'b0;
                    stall_left--;
                end else begin
                    ack_iter[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk_all_zero(int inst, string tag);
        chk_eq({tag, "_rom_enable"},  32'(rom_enable[inst]),  32'd0);
        chk_eq({tag, "_rom_address"}, 32'(rom_address[inst]), 32'd0);
        chk_eq({tag, "_angle_out"},   angle_out[inst],        32'd0);
        chk_eq({tag, "_iter_count"},  32'(iter_count[inst]),  32'd0);
        chk_eq({tag, "_iter_valid"},  32'(iter_valid[inst]),  32'd0);
        chk_eq({tag, "_busy"},        32'(busy[inst]),        32'd0);
        chk_eq({tag, "_done"},        32'(done[inst]),        32'd0);
    endtask

    // Queue the expected words (and optional done) then pulse beg_seq for one edge.
    task automatic start_seq(int inst, int n, bit with_done);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.inst = inst; x.k = k; x.angle = atan_word(k); x.is_done = 1'b0;
            sb_q.push_back(x);
        end
        if (with_done) begin
            x.inst = inst; x.k = 0; x.angle = 32'd0; x.is_done = 1'b1;
            sb_q.push_back(x);
        end
        beg_seq[inst] = 1'b1;
        @(posedge clk);
        #1;
        beg_seq[inst] = 1'b0;
        t_start = cyc;
        chk_eq("start_rom_enable",  32'(rom_enable[inst]),  32'd1);
        chk_eq("start_rom_address", 32'(rom_address[inst]), 32'd0);
        chk_eq("start_busy",        32'(busy[inst]),        32'd1);
    endtask

    task automatic wait_done(int inst, int budget, int exp_lat);
        int el;
        el = -1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (done[inst] === 1'b1) begin
                el = cyc - t_start;
                break;
            end
        end
        chk_eq("done_latency", 32'(el), 32'(exp_lat));
    endtask

    task automatic wait_present(int inst, int k, int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (iter_valid[inst] === 1'b1 && iter_count[inst] == 5'(k)) begin
                seen = 1'b1;
                break;
            end
        end
        chk_eq("present_reached", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(int inst, int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (sb_q.size() == 0 && busy[inst] === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk_eq("drain_to_idle", 32'(ok), 32'd1);
        if (!ok) sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) beg_seq[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk_all_zero(i, "reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: full 24-iteration run with ack always high.
        en0 = g_dut[0].en_cnt;
        start_seq(0, 24, 1'b1);
        wait_done(0, 200, 72);
        wait_idle(0, 20);
        chk_eq("t1_rom_enable_count", 32'(g_dut[0].en_cnt - en0), 32'd24);

        // 2: five stalled cycles while k=3 is presented.
        repeat (2) @(posedge clk);
        #1;
        stall_inst = 0; stall_k = 3; stall_left = 5;
        start_seq(0, 24, 1'b1);
        wait_done(0, 200, 77);
        wait_idle(0, 20);

        // 3: start requests while busy and in the done cycle are ignored.
        repeat (2) @(posedge clk);
        #1;
        en0 = g_dut[0].en_cnt;
        start_seq(0, 24, 1'b1);
        wait_present(0, 5, 40);
        beg_seq[0] = 1'b1;
        @(posedge clk);
        #1;
        beg_seq[0] = 1'b0;
        wait_done(0, 200, 72);
        beg_seq[0] = 1'b1;
        @(posedge clk);
        #1;
        beg_seq[0] = 1'b0;
        chk_eq("t3_done_cleared", 32'(done[0]), 32'd0);
        chk_eq("t3_no_restart_busy", 32'(busy[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("t3_idle_busy", 32'(busy[0]), 32'd0);
        chk_eq("t3_idle_rom_enable", 32'(rom_enable[0]), 32'd0);
        chk_eq("t3_idle_valid", 32'(iter_valid[0]), 32'd0);
        chk_eq("t3_idle_angle_retained", angle_out[0], atan_word(23));
        chk_eq("t3_idle_count_retained", 32'(iter_count[0]), 32'd23);
        wait_idle(0, 5);
        chk_eq("t3_rom_enable_count", 32'(g_dut[0].en_cnt - en0), 32'd24);

        // 4: reset while k=10 is held, then a clean restart.
        stall_inst = 0; stall_k = 10; stall_left = 1000;
        start_seq(0, 11, 1'b0);
        wait_present(0, 10, 60);
        chk_eq("t4_held_angle", angle_out[0], atan_word(10));
        rst = 1'b1;
        @(posedge clk);
        #1;
        stall_left = 0;
        chk_all_zero(0, "midreset");
        chk_eq("t4_leftover_entries", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t4_no_done_after_reset", 32'(done[0]), 32'd0);
        start_seq(0, 24, 1'b1);
        wait_done(0, 200, 72);
        wait_idle(0, 20);

        // 5: ITER=32 ends at index 31, ITER=1 runs a single iteration.
        en0 = g_dut[1].en_cnt;
        start_seq(1, 32, 1'b1);
        wait_done(1, 250, 96);
        chk_eq("t5_final_angle", angle_out[1], 32'h30000000);
        chk_eq("t5_final_count", 32'(iter_count[1]), 32'd31);
        wait_idle(1, 20);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t5_no_wrap_enable", 32'(rom_enable[1]), 32'd0);
        chk_eq("t5_rom_enable_count", 32'(g_dut[1].en_cnt - en0), 32'd32);

        en0 = g_dut[2].en_cnt;
        start_seq(2, 1, 1'b1);
        wait_done(2, 20, 3);
        chk_eq("t5_iter1_angle", angle_out[2], 32'h3f490fdb);
        wait_idle(2, 20);
        chk_eq("t5_iter1_enable_count", 32'(g_dut[2].en_cnt - en0), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk_eq("queue_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
